// File: rtl/array_match_pipe.sv
// array_match_pipe
//   Two-stage pipelined array matcher. Each accepted transaction carries SIZE
//   entries (value + per-entry valid), a key and a compare mode. The result
//   appears two cycles after acceptance when there is no backpressure.
//
//   The result is a per-entry match mask, a popcount, the lowest matching
//   index and an any-match flag. A saturating counter tallies delivered
//   results that had any match.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid/ready   input handshake
//   in_value         SIZE*WIDTH packed entries; entry j at [j*WIDTH +: WIDTH]
//   in_entry_vld     per-entry valid; an invalid entry never matches
//   match_value      compare key (unsigned)
//   mode             00 EQ, 01 NE, 10 LT (value < key), 11 GE (value >= key)
//   out_valid/ready  output handshake
//   out_mask         per-entry match mask
//   out_count        popcount of out_mask
//   out_first_idx    lowest set bit of out_mask; 0 when the mask is empty
//   out_any          |out_mask
//   stat_clr         synchronous clear of hit_count; wins over an increment
//   hit_count        saturating count of delivered results with out_any=1
module array_match_pipe #(
  parameter int WIDTH  = 4,
  parameter int SIZE   = 8,
  parameter int STAT_W = 16,
  localparam int IDX_W = $clog2(SIZE),
  localparam int CNT_W = $clog2(SIZE + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SIZE*WIDTH-1:0]   in_value,
  input  logic [SIZE-1:0]         in_entry_vld,
  input  logic [WIDTH-1:0]        match_value,
  input  logic [1:0]              mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SIZE-1:0]         out_mask,
  output logic [CNT_W-1:0]        out_count,
  output logic [IDX_W-1:0]        out_first_idx,
  output logic                    out_any,
  input  logic                    stat_clr,
  output logic [STAT_W-1:0]       hit_count
);

  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  function automatic logic cmp_entry(input logic [WIDTH-1:0] v,
                                     input logic [WIDTH-1:0] k,
                                     input logic [1:0]       m);
    logic r;
    case (m)
      2'b00:   r = (v == k);
      2'b01:   r = (v != k);
      2'b10:   r = (v <  k);
      default: r = (v >= k);
    endcase
    return r;
  endfunction

  function automatic logic [SIZE-1:0] compare_mask(input logic [SIZE*WIDTH-1:0] vals,
                                                   input logic [SIZE-1:0]       vld,
                                                   input logic [WIDTH-1:0]      k,
                                                   input logic [1:0]            m);
    logic [SIZE-1:0] r;
    for (int j = 0; j < SIZE; j++) begin
      r[j] = vld[j] && cmp_entry(vals[j*WIDTH +: WIDTH], k, m);
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [SIZE-1:0] m);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int j = 0; j < SIZE; j++) begin
      c = c + CNT_W'(m[j]);
    end
    return c;
  endfunction

  // Scan from the top down so the lowest set bit is the last one written.
  function automatic logic [IDX_W-1:0] first_index(input logic [SIZE-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int j = SIZE - 1; j >= 0; j--) begin
      if (m[j]) idx = IDX_W'(j);
    end
    return idx;
  endfunction

  logic            vld_p1;
  logic [SIZE-1:0] mask_p1;
  logic            vld_p2;
  logic [SIZE-1:0] mask_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic [IDX_W-1:0] idx_p2;
  logic            any_p2;

  logic s2_free;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  // No skid buffer: in_ready follows out_ready combinationally.
  assign s2_free  = !vld_p2 || out_ready;
  assign s1_adv   = vld_p1 && s2_free;
  assign in_ready = !vld_p1 || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = vld_p2 && out_ready;

  // ---- Stage 1: compare; key and mode are not kept past this point ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      mask_p1 <= '0;
    end else begin
      if (in_fire) begin
        vld_p1  <= 1'b1;
        mask_p1 <= compare_mask(in_value, in_entry_vld, match_value, mode);
      end else if (s1_adv) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  // ---- Stage 2: reduce mask; drives all outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2  <= 1'b0;
      mask_p2 <= '0;
      cnt_p2  <= '0;
      idx_p2  <= '0;
      any_p2  <= 1'b0;
    end else if (s2_free) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        mask_p2 <= mask_p1;
        cnt_p2  <= popcount(mask_p1);
        idx_p2  <= first_index(mask_p1);
        any_p2  <= |mask_p1;
      end
    end
  end

  // ---- Statistics: counts delivered any-match results ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (stat_clr) begin
      hit_count <= '0;
    end else if (out_fire && any_p2 && (hit_count != STAT_MAX)) begin
      hit_count <= hit_count + 1'b1;
    end
  end

  assign out_valid     = vld_p2;
  assign out_mask      = mask_p2;
  assign out_count     = cnt_p2;
  assign out_first_idx = idx_p2;
  assign out_any       = any_p2;

endmodule

// File: tb/tb_array_match_pipe.sv
// tb_array_match_pipe
//   Directed bench for array_match_pipe (WIDTH=4, SIZE=8, STAT_W=2).
//   A vector table covers the compare modes and boundary masks; hand-written
//   sequences cover backpressure, counter saturation/clear and mid-run reset.
module tb_array_match_pipe;

  localparam int WIDTH  = 4;
  localparam int SIZE   = 8;
  localparam int STAT_W = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic [7:0]  in_entry_vld;
  logic [3:0]  match_value;
  logic [1:0]  mode;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_mask;
  logic [3:0]  out_count;
  logic [2:0]  out_first_idx;
  logic        out_any;
  logic        stat_clr;
  logic [1:0]  hit_count;

  always #5 clk = ~clk;

  array_match_pipe #(.WIDTH(WIDTH), .SIZE(SIZE), .STAT_W(STAT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_value     (in_value),
    .in_entry_vld (in_entry_vld),
    .match_value  (match_value),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_mask     (out_mask),
    .out_count    (out_count),
    .out_first_idx(out_first_idx),
    .out_any      (out_any),
    .stat_clr     (stat_clr),
    .hit_count    (hit_count)
  );

  typedef struct {
    logic [31:0] value;
    logic [7:0]  vld;
    logic [3:0]  key;
    logic [1:0]  md;
    logic [7:0]  mask;
    logic [3:0]  cnt;
    logic [2:0]  idx;
    logic        any;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int hit_model = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] v, input logic [7:0] vl,
                       input logic [3:0] k, input logic [1:0] m);
    in_valid     = 1'b1;
    in_value     = v;
    in_entry_vld = vl;
    match_value  = k;
    mode         = m;
  endtask

  vec_t vecs[10];
  logic [7:0] bp_exp[4];
  logic [7:0] got[$];

  initial begin
    // entries 7..0 = 2,3,1,2,3,2,1,2 -> list {2,1,2,3,2,1,3,2} from entry 0
    vecs[0] = '{32'h2312_3212, 8'hFF, 4'd2,  2'b00, 8'h95, 4'd4, 3'd0, 1'b1};
    vecs[1] = '{32'h2312_3212, 8'h00, 4'd2,  2'b00, 8'h00, 4'd0, 3'd0, 1'b0};
    vecs[2] = '{32'h2312_3212, 8'hFF, 4'd0,  2'b10, 8'h00, 4'd0, 3'd0, 1'b0};
    vecs[3] = '{32'h2312_3212, 8'hFF, 4'd0,  2'b11, 8'hFF, 4'd8, 3'd0, 1'b1};
    vecs[4] = '{32'h2312_3212, 8'hFF, 4'd2,  2'b01, 8'h6A, 4'd4, 3'd1, 1'b1};
    vecs[5] = '{32'h2312_3212, 8'hFF, 4'd3,  2'b10, 8'hB7, 4'd6, 3'd0, 1'b1};
    vecs[6] = '{32'h2312_3212, 8'hF0, 4'd3,  2'b11, 8'h40, 4'd1, 3'd6, 1'b1};
    vecs[7] = '{32'hFFFF_FFFF, 8'h80, 4'hF,  2'b00, 8'h80, 4'd1, 3'd7, 1'b1};
    vecs[8] = '{32'h0000_0000, 8'hFF, 4'hF,  2'b11, 8'h00, 4'd0, 3'd0, 1'b0};
    vecs[9] = '{32'h1000_0000, 8'hFF, 4'd0,  2'b01, 8'h80, 4'd1, 3'd7, 1'b1};
    bp_exp  = '{8'h01, 8'h02, 8'h04, 8'h08};

    rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_entry_vld = '0;
    match_value = '0; mode = '0; out_ready = 1'b1; stat_clr = 1'b0;
    tick(); tick();
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_mask", {24'b0, out_mask}, 0);
    check("rst_out_count", {28'b0, out_count}, 0);
    check("rst_hit_count", {30'b0, hit_count}, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 1);

    // ---- table-driven single transactions ----
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].value, vecs[i].vld, vecs[i].key, vecs[i].md);
      check($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 1);
      tick();
      in_valid = 1'b0;
      check($sformatf("v%0d_early_valid", i), {31'b0, out_valid}, 0);
      tick();
      check($sformatf("v%0d_valid", i), {31'b0, out_valid}, 1);
      check($sformatf("v%0d_mask", i), {24'b0, out_mask}, {24'b0, vecs[i].mask});
      check($sformatf("v%0d_count", i), {28'b0, out_count}, {28'b0, vecs[i].cnt});
      check($sformatf("v%0d_idx", i), {29'b0, out_first_idx}, {29'b0, vecs[i].idx});
      check($sformatf("v%0d_any", i), {31'b0, out_any}, {31'b0, vecs[i].any});
      tick();
      if (vecs[i].any && hit_model < 3) hit_model++;
      check($sformatf("v%0d_drain", i), {31'b0, out_valid}, 0);
      check($sformatf("v%0d_hit", i), {30'b0, hit_count}, hit_model);
    end

    // ---- backpressure: four back-to-back, out_ready low for 5 cycles ----
    out_ready = 1'b0;
    #1;
    drive(32'h7654_3210, 8'hFF, 4'd0, 2'b00);
    check("bp_ready0", {31'b0, in_ready}, 1);
    tick();
    drive(32'h7654_3210, 8'hFF, 4'd1, 2'b00);
    check("bp_ready1", {31'b0, in_ready}, 1);
    tick();
    drive(32'h7654_3210, 8'hFF, 4'd2, 2'b00);
    check("bp_ready_drop", {31'b0, in_ready}, 0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_hold_valid%0d", c), {31'b0, out_valid}, 1);
      check($sformatf("bp_hold_mask%0d", c), {24'b0, out_mask}, 32'h01);
      check($sformatf("bp_hold_count%0d", c), {28'b0, out_count}, 1);
      check($sformatf("bp_hold_idx%0d", c), {29'b0, out_first_idx}, 0);
      check($sformatf("bp_hold_ready%0d", c), {31'b0, in_ready}, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    begin
      int k;
      logic fire_in;
      k = 2;
      got.delete();
      for (int c = 0; c < 30 && got.size() < 4; c++) begin
        if (out_valid && out_ready) got.push_back(out_mask);
        fire_in = in_valid && in_ready;
        tick();
        if (fire_in) begin
          k++;
          if (k < 4) drive(32'h7654_3210, 8'hFF, 4'(k), 2'b00);
          else in_valid = 1'b0;
        end
      end
    end
    check("bp_result_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) check($sformatf("bp_order%0d", i), {24'b0, got[i]}, {24'b0, bp_exp[i]});
    end
    tick();
    check("bp_drained", {31'b0, out_valid}, 0);
    check("bp_hit_sat", {30'b0, hit_count}, 3);

    // ---- counter: clear, saturate with 5 back-to-back hits, clear on fire ----
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("sat_clr", {30'b0, hit_count}, 0);
    drive(32'h2312_3212, 8'hFF, 4'd2, 2'b00);
    for (int c = 0; c < 5; c++) tick();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    check("sat_hold3", {30'b0, hit_count}, 3);
    tick();
    check("sat_still3", {30'b0, hit_count}, 3);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("sat_clr2", {30'b0, hit_count}, 0);
    drive(32'h2312_3212, 8'hFF, 4'd2, 2'b00);
    tick();
    in_valid = 1'b0;
    tick();
    check("clrfire_valid", {31'b0, out_valid}, 1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("clrfire_hit", {30'b0, hit_count}, 0);
    drive(32'h2312_3212, 8'hFF, 4'd2, 2'b00);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("after_clr_inc", {30'b0, hit_count}, 1);

    // ---- reset mid-operation ----
    drive(32'h2312_3212, 8'hFF, 4'd2, 2'b00);
    tick();
    drive(32'h2312_3212, 8'hFF, 4'd3, 2'b00);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", {31'b0, out_valid}, 0);
    check("mrst_hit", {30'b0, hit_count}, 0);
    check("mrst_mask", {24'b0, out_mask}, 0);
    tick();
    rst_n = 1'b1;
    check("mrst_in_ready", {31'b0, in_ready}, 1);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mrst_no_stale%0d", c), {31'b0, out_valid}, 0);
      tick();
    end
    check("mrst_hit_after", {30'b0, hit_count}, 0);
    drive(32'h2312_3212, 8'hFF, 4'd1, 2'b00);
    tick();
    in_valid = 1'b0;
    tick();
    check("mrst_resume_valid", {31'b0, out_valid}, 1);
    check("mrst_resume_mask", {24'b0, out_mask}, 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
